lpf_decim_buf: RTL and testbench

- Downstream stage of the 12-bit FIR low-pass filter; consumes its filtered output at the f_s sample rate.
- Decimates by 2^DECIM_LOG2 using accumulate-and-dump averaging.
- Buffers the results in a small FIFO with a valid/ready handshake toward the consumer (e.g. a serial/telemetry packer), and flags sticky overflow.

---
 rtl/lpf_pkg.sv | 6 +
 rtl/lpf_sample_fifo.sv | 61 ++++++
 rtl/lpf_decim_buf.sv | 96 +++++++++
 tb/tb_lpf_decim_buf.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lpf_pkg.sv
// Shared constants and sample type for the FIR low-pass chain and its downstream stages.
package lpf_pkg;
  localparam int LPF_DW         = 12;
  localparam int LPF_DECIM_LOG2 = 2;
  typedef logic signed [LPF_DW-1:0] sample_t;
endpackage

// File: rtl/lpf_sample_fifo.sv
// Synchronous show-ahead FIFO; a push while full without a pop is dropped and reported as a pulse.
module lpf_sample_fifo #(
  parameter int DW      = 12,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [DW-1:0]      wdata_i,
  input  logic               pop_i,
  output logic [DW-1:0]      rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   level_o,
  output logic               drop_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);

  logic [DW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               pop_s, wr_s;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_FULL);
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_s  = pop_i & ~empty_o;
    wr_s   = push_i & (~full_o | pop_s);
    drop_o = push_i & full_o & ~pop_s;
    wr_d   = wr_s  ? wr_q + FIFO_AW'(1) : wr_q;
    rd_d   = pop_s ? rd_q + FIFO_AW'(1) : rd_q;
    case ({wr_s, pop_s})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_q] <= wdata_i;
    end
  end
endmodule

// File: rtl/lpf_decim_buf.sv
// Accumulate-and-dump decimator behind the FIR output, buffered toward a valid/ready consumer.
module lpf_decim_buf
  import lpf_pkg::*;
#(
  parameter int DW         = LPF_DW,
  parameter int DECIM_LOG2 = LPF_DECIM_LOG2,
  parameter int FIFO_AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_s,
  input  logic signed [DW-1:0] din,
  input  logic                 en,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 ovf
);
  localparam int AW = DW + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = DECIM_LOG2'((1 << DECIM_LOG2) - 1);

  logic                   pl0_q, pl1_q, cap_q, stb_s;
  logic signed [AW-1:0]   acc_q, acc_d, sum_s, avg_s;
  logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
  logic                   push_s, drop_s, empty_s, full_s;
  logic [DW-1:0]          res_s, rdata_s;
  logic                   ovf_q, ovf_d;

  assign stb_s = pl0_q & ~pl1_q;

  // din is sampled one clk after the strobe, once the FIR output register has updated.
  always_comb begin
    sum_s  = acc_q + {{DECIM_LOG2{din[DW-1]}}, din};
    avg_s  = sum_s >>> DECIM_LOG2;
    res_s  = avg_s[DW-1:0];
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    push_s = 1'b0;
    ovf_d  = ovf_q | drop_s;
    if (!en) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (cap_q) begin
      if (cnt_q == CNT_LAST) begin
        push_s = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + DECIM_LOG2'(1);
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pl0_q <= 1'b0;
      pl1_q <= 1'b0;
      cap_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pl0_q <= f_s;
      pl1_q <= pl0_q;
      cap_q <= stb_s;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  lpf_sample_fifo #(
    .DW      (DW),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i (res_s),
    .pop_i   (dout_ready),
    .rdata_o (rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (fifo_level),
    .drop_o  (drop_s)
  );

  assign dout       = rdata_s;
  assign dout_valid = ~empty_s;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_lpf_decim_buf.sv
// Scoreboard bench: a queue-based model predicts the FIFO contents; a monitor checks every cycle.
module tb_lpf_decim_buf;
  localparam int DECIM = 4;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               f_s = 1'b0;
  logic               en  = 1'b1;
  logic               dout_ready = 1'b0;
  logic [11:0]        din = 12'd0;
  logic signed [11:0] dout;
  logic               dout_valid;
  logic [2:0]         fifo_level;
  logic               ovf;

  int  exp_q[$];
  int  frame[$];
  bit  ovf_exp = 1'b0;
  bit  mon_on  = 1'b0;
  int  n_vec   = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  lpf_decim_buf #(.DW(12), .DECIM_LOG2(2), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .f_s(f_s), .din(din), .en(en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .fifo_level(fifo_level), .ovf(ovf)
  );

  function automatic int floor_avg(input int s);
    int q;
    q = s / DECIM;
    if ((s % DECIM) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: a completed frame yields its floored mean, queued unless the buffer is full.
  task automatic model_sample(input int v);
    int sum;
    if (en) begin
      frame.push_back(v);
      if (frame.size() == DECIM) begin
        sum = 0;
        foreach (frame[i]) sum += frame[i];
        frame.delete();
        if (exp_q.size() < DEPTH) exp_q.push_back(floor_avg(sum));
        else ovf_exp = 1'b1;
      end
    end
  endtask

  // mode 0: dout_ready untouched, 1: random, 2: ready only in the cycle of the push
  task automatic send(input int v, input int mode);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin din = 12'(v); f_s = 1'b1; end
      if (k == 2) f_s = 1'b0;
      if (mode == 1) dout_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) dout_ready = (k == 2);
      if (k == 2) begin #3; model_sample(v); end
    end
  endtask

  task automatic send_frame(input int v);
    for (int i = 0; i < DECIM; i++) send(v, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_q.delete();
    frame.delete();
    ovf_exp = 1'b0;
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_level", int'(fifo_level), 0);
  endtask

  task automatic en_pulse();
    @(negedge clk); en = 1'b0; frame.delete();
    @(negedge clk); en = 1'b1;
  endtask

  task automatic drain(input int n);
    dout_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (mon_on) begin
        check("level", int'(fifo_level), exp_q.size());
        check("valid", int'(dout_valid), int'(exp_q.size() != 0));
        check("ovf", int'(ovf), int'(ovf_exp));
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", int'(dout_valid), 0);
          end else begin
            check("dout", int'(dout), exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stim
    int v;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_dout", int'(dout), 0);
    mon_on = 1'b1;

    dout_ready = 1'b1;
    send(100, 0); send(101, 0); send(102, 0); send(103, 0);
    send(-1, 0); send(-1, 0); send(-1, 0); send(-2, 0);
    send_frame(-2048);
    send_frame(2047);

    send(5, 0); send(6, 0);
    en_pulse();
    send_frame(10);

    dout_ready = 1'b0;
    for (int f = 1; f <= 5; f++) send_frame(f);
    check("ovf_full_level", int'(fifo_level), DEPTH);
    check("ovf_set", int'(ovf), 1);
    drain(8);

    do_reset();
    dout_ready = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(7 + f);
    send(9, 0); send(9, 0); send(9, 0); send(9, 2);
    check("simul_level", int'(fifo_level), DEPTH);
    check("simul_ovf", int'(ovf), 0);
    drain(8);

    dout_ready = 1'b0;
    send_frame(20); send_frame(21); send_frame(22);
    send(30, 0); send(31, 0);
    do_reset();
    send(40, 0); send(41, 0); send(42, 0); send(44, 0);
    drain(4);

    for (int f = 0; f < 25; f++) begin
      for (int s = 0; s < DECIM; s++) begin
        if ($urandom_range(0, 19) == 0) en_pulse();
        v = int'($signed(12'($urandom)));
        send(v, 1);
      end
    end
    drain(12);
    check("final_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
